// File: rtl/cmd_proc_pkg.sv
// cmd_proc shared types: opcodes, FSM states, command layout
// and response words.
package cmd_proc_pkg;

  typedef enum logic [3:0] {
    OP_WRITE  = 4'h1,
    OP_READ   = 4'h2,
    OP_SAMPLE = 4'h3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT_SAMP,
    SEND,
    GAP
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam logic [15:0] RESP_ACK = 16'hA5A5;
  localparam logic [15:0] RESP_NAK = 16'hEEEE;
  localparam logic [15:0] RESP_TMO = 16'hDEAD;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// Used for TX pacing and sample timeout.
module gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cmd_proc.sv
// Command processor: register r/w and pressure sampling with
// paced 16-bit responses. Optional CMD_PROC_QUEUE_EN holding buffer.
module cmd_proc
  import cmd_proc_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int TX_GAP_CYC   = 52100,
  parameter int SAMP_TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           cmd,
  input  logic                  cmd_rdy,
  output logic [15:0]           tx_data,
  output logic                  trmt,
  output logic                  press_req,
  input  logic                  press_vld,
  input  logic [15:0]           press_data,
  output logic [16*NUM_REGS-1:0] cfg_regs,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int GW = $clog2(TX_GAP_CYC + 1);
  localparam int TW = $clog2(SAMP_TIMEOUT + 1);

  state_e      state, state_d;
  cmd_t        cmd_in, cmd_q, cmd_src;
  cmd_t        hold_cmd;
  logic        hold_vld;
  logic        cmd_ld;
  logic [15:0] regs [NUM_REGS];
  logic [15:0] rd_val;
  logic        addr_ok;
  logic        wr_en;
  logic        tx_ld;
  logic [15:0] tx_nxt;
  logic        gap_ld, gap_dec, gap_zero;
  logic        tmo_ld, tmo_dec, tmo_zero;
  logic        drop_inc;

  assign cmd_in  = cmd;
  assign addr_ok = 5'(cmd_q.addr) < 5'(NUM_REGS);
  assign trmt      = (state == SEND);
  assign press_req = (state == EXEC) && (cmd_q.op == OP_SAMPLE);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_q.addr == 4'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    state_d = state;
    cmd_ld  = 1'b0;
    cmd_src = cmd_in;
    wr_en   = 1'b0;
    tx_ld   = 1'b0;
    tx_nxt  = RESP_NAK;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    tmo_ld  = 1'b0;
    tmo_dec = 1'b0;
    unique case (state)
      IDLE: begin
        // a buffered command takes priority over a fresh one
        if (hold_vld) begin
          cmd_ld  = 1'b1;
          cmd_src = hold_cmd;
          state_d = EXEC;
        end else if (cmd_rdy) begin
          cmd_ld  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        tx_ld   = 1'b1;
        state_d = SEND;
        unique case (1'b1)
          (cmd_q.op == OP_WRITE): begin
            wr_en  = addr_ok;
            tx_nxt = addr_ok ? RESP_ACK : RESP_NAK;
          end
          (cmd_q.op == OP_READ): begin
            tx_nxt = addr_ok ? rd_val : RESP_NAK;
          end
          (cmd_q.op == OP_SAMPLE): begin
            tx_ld   = 1'b0;
            tmo_ld  = 1'b1;
            state_d = WAIT_SAMP;
          end
          default: tx_nxt = RESP_NAK;
        endcase
      end
      WAIT_SAMP: begin
        if (press_vld) begin
          tx_ld   = 1'b1;
          tx_nxt  = press_data;
          state_d = SEND;
        end else if (tmo_zero) begin
          tx_ld   = 1'b1;
          tx_nxt  = RESP_TMO;
          state_d = SEND;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      SEND: begin
        gap_ld  = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        if (gap_zero) state_d = IDLE;
        else          gap_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cmd_q    <= '0;
      tx_data  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      if (cmd_ld) cmd_q <= cmd_src;
      if (tx_ld)  tx_data <= tx_nxt;
      if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && cmd_q.addr == 4'(i)) regs[i] <= cmd_q.data;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
    assign cfg_regs[16*i +: 16] = regs[i];
  end

`ifdef CMD_PROC_QUEUE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_cmd <= '0;
    end else if (state == IDLE) begin
      // buffered entry is consumed; a same-cycle arrival refills it
      if (hold_vld) begin
        hold_vld <= cmd_rdy;
        if (cmd_rdy) hold_cmd <= cmd_in;
      end
    end else if (cmd_rdy && !hold_vld) begin
      hold_vld <= 1'b1;
      hold_cmd <= cmd_in;
    end
  end

  assign drop_inc = cmd_rdy && (state != IDLE) && hold_vld;
`else
  assign hold_vld = 1'b0;
  assign hold_cmd = '0;
  assign drop_inc = cmd_rdy && (state != IDLE);
`endif

  gap_timer #(.W(GW)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_ld),
    .load_val (GW'(TX_GAP_CYC - 1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  gap_timer #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_ld),
    .load_val (TW'(SAMP_TIMEOUT - 1)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

endmodule

// File: tb/tb_cmd_proc.sv
// Directed self-checking bench for cmd_proc.
// Short gap/timeout parameters keep the run brief.
module tb_cmd_proc;

  localparam int NR  = 8;
  localparam int GAP = 20;
  localparam int TMO = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [23:0]       cmd = '0;
  logic              cmd_rdy = 1'b0;
  logic [15:0]       tx_data;
  logic              trmt;
  logic              press_req;
  logic              press_vld = 1'b0;
  logic [15:0]       press_data = '0;
  logic [16*NR-1:0]  cfg_regs;
  logic              busy;
  logic [7:0]        drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tq[$];
  logic [15:0] dq[$];
  logic [16*NR-1:0] exp_regs = '0;

  cmd_proc #(
    .NUM_REGS     (NR),
    .TX_GAP_CYC   (GAP),
    .SAMP_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .press_req  (press_req),
    .press_vld  (press_vld),
    .press_data (press_data),
    .cfg_regs   (cfg_regs),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trmt) begin
      tq.push_back(cyc);
      dq.push_back(tx_data);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int tq_at(input int i);
    return (i < tq.size()) ? tq[i] : -1;
  endfunction

  function automatic logic [31:0] dq_at(input int i);
    return (i < dq.size()) ? {16'h0, dq[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic clr();
    tq.delete();
    dq.delete();
  endtask

  task automatic pulse(input logic [23:0] c, output int c0);
    cmd     = c;
    cmd_rdy = 1'b1;
    c0      = cyc;
    @(negedge clk);
    cmd_rdy = 1'b0;
    cmd     = '0;
  endtask

  task automatic till(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int low = 0;
    for (int i = 0; i < 400 && low < 3; i++) begin
      @(negedge clk);
      low = busy ? 0 : low + 1;
    end
    chk("idle_reached", low >= 3, 1);
  endtask

  task automatic wait_free();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0, c1, n0;

    repeat (3) @(negedge clk);
    chk("rst_trmt", trmt, 0);
    chk("rst_preq", press_req, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_tx", tx_data, 0);
    chk("init_cfg", cfg_regs, 0);
    chk("init_drop", drop_cnt, 0);

    // reset in the middle of the gap
    clr();
    pulse(24'h160777, c0);
    till(c0 + 6);
    chk("mid_busy", busy, 1);
    chk("mid_tx", tx_data, 16'hA5A5);
    rst = 1'b1;
    #1;
    chk("mrst_trmt", trmt, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tx", tx_data, 0);
    chk("mrst_cfg", cfg_regs, 0);
    chk("mrst_preq", press_req, 0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (2 * GAP) @(negedge clk);
    chk("mrst_no_trmt", tq.size(), 0);

    // write then read
    clr();
    pulse(24'h13BEEF, c0);
    exp_regs[63:48] = 16'hBEEF;
    wait_idle();
    chk("wr_cyc", tq_at(0), c0 + 2);
    chk("wr_ack", dq_at(0), 16'hA5A5);
    chk("wr_cfg", cfg_regs, exp_regs);
    clr();
    pulse(24'h230000, c0);
    wait_idle();
    chk("rd_cyc", tq_at(0), c0 + 2);
    chk("rd_val", dq_at(0), 16'hBEEF);

    // stray press_vld while idle
    clr();
    press_vld  = 1'b1;
    press_data = 16'h5555;
    @(negedge clk);
    press_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("vld_idle_busy", busy, 0);
    chk("vld_idle_trmt", tq.size(), 0);

    // sample with data
    pulse(24'h300000, c0);
    chk("preq_on", press_req, 1);
    till(c0 + 2);
    chk("preq_off", press_req, 0);
    till(c0 + 6);
    press_vld  = 1'b1;
    press_data = 16'h1234;
    @(negedge clk);
    press_vld = 1'b0;
    wait_idle();
    chk("samp_n", tq.size(), 1);
    chk("samp_cyc", tq_at(0), c0 + 7);
    chk("samp_val", dq_at(0), 16'h1234);

    // sample timeout
    clr();
    pulse(24'h300000, c0);
    wait_idle();
    chk("tmo_cyc", tq_at(0), c0 + 2 + TMO);
    chk("tmo_val", dq_at(0), 16'hDEAD);

    // NAK cases
    clr();
    pulse(24'h1F0001, c0);
    wait_idle();
    chk("nak_wr_cyc", tq_at(0), c0 + 2);
    chk("nak_wr", dq_at(0), 16'hEEEE);
    clr();
    pulse(24'h180001, c0);
    wait_idle();
    chk("nak_wr8", dq_at(0), 16'hEEEE);
    clr();
    pulse(24'h700000, c0);
    wait_idle();
    chk("nak_op7", dq_at(0), 16'hEEEE);
    clr();
    pulse(24'h2A0000, c0);
    wait_idle();
    chk("nak_rd", dq_at(0), 16'hEEEE);
    chk("nak_cfg", cfg_regs, exp_regs);
    chk("nak_drop", drop_cnt, 0);

    // collisions during the gap
    clr();
    n0 = drop_cnt;
    pulse(24'h124321, c0);
    exp_regs[47:32] = 16'h4321;
    till(c0 + 5);
    pulse(24'h220000, c1);
    till(c0 + 7);
    pulse(24'h200000, c1);
    wait_idle();
    chk("col_cyc0", tq_at(0), c0 + 2);
    chk("col_ack", dq_at(0), 16'hA5A5);
`ifdef CMD_PROC_QUEUE_EN
    chk("col_n", tq.size(), 2);
    chk("col_cyc1", tq_at(1), c0 + 2 + GAP + 3);
    chk("col_val1", dq_at(1), 16'h4321);
    chk("col_drop", drop_cnt, n0 + 1);
`else
    chk("col_n", tq.size(), 1);
    chk("col_drop", drop_cnt, n0 + 2);
`endif

    // arrival on the last gap cycle
    clr();
    n0 = drop_cnt;
    pulse(24'h170404, c0);
    exp_regs[127:112] = 16'h0404;
    till(c0 + 2 + GAP);
    pulse(24'h270000, c1);
    wait_idle();
`ifdef CMD_PROC_QUEUE_EN
    chk("edge_n", tq.size(), 2);
    chk("edge_cyc1", tq_at(1), c0 + 2 + GAP + 3);
    chk("edge_val1", dq_at(1), 16'h0404);
    chk("edge_drop", drop_cnt, n0);
`else
    chk("edge_n", tq.size(), 1);
    chk("edge_drop", drop_cnt, n0 + 1);
`endif
    chk("edge_cfg", cfg_regs, exp_regs);

    // back-to-back pacing, read-after-write
    clr();
    pulse(24'h150055, c0);
    exp_regs[95:80] = 16'h0055;
    for (int k = 0; k < 3; k++) begin
      wait_free();
      pulse(24'h250000, c1);
    end
    wait_idle();
    chk("pace_n", tq.size(), 4);
    for (int i = 1; i < 4; i++) begin
      chk("pace_gap", (tq_at(i) - tq_at(i - 1)) >= GAP + 2, 1);
      chk("pace_val", dq_at(i), 16'h0055);
    end
    chk("pace_cfg", cfg_regs, exp_regs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_proc.md
Name: cmd_proc

Overview:
- Command processor sitting directly downstream of the serial transceiver.
- Consumes the 24-bit `cmd` / `cmd_rdy` it produces, executes register read/write and pressure-sample commands, and returns 16-bit responses on `tx_data` / `trmt`.
- Paces its own transmissions, because the transceiver exposes no done/busy indication.

Parameters:
- NUM_REGS, 8: number of 16-bit config registers (max 16).
- TX_GAP_CYC, 52100: cycles after `trmt` before another `trmt` may issue (covers 2 bytes x 10 bits at 2604 clk/bit).
- SAMP_TIMEOUT, 1000: cycles to wait for `press_vld` after `press_req`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd  in  24  [23:20] opcode, [19:16] addr, [15:0] data
- cmd_rdy  in  1  one-cycle pulse: `cmd` valid
- tx_data  out  16  response word; registered, held until next `trmt`
- trmt  out  1  one-cycle pulse starting a 16-bit response transmission
- press_req  out  1  one-cycle pulse requesting a pressure sample
- press_vld  in  1  one-cycle pulse: `press_data` valid
- press_data  in  16  corrected pressure reading
- cfg_regs  out  16*NUM_REGS  flat register file, reg i at [16i+15:16i]
- busy  out  1  high whenever state != IDLE
- drop_cnt  out  8  saturating count of discarded commands

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - tx_data=0, trmt=0, press_req=0, busy=0, drop_cnt=0.
  - All cfg_regs=0.
  - Gap counter cleared; holding buffer empty.
  - Reset mid-operation aborts any transaction; no `trmt` is issued afterwards.
- States: IDLE, EXEC, WAIT_SAMP, SEND, GAP.
- IDLE:
  - `cmd_rdy`=1 at edge 0 → `cmd` latched, go to EXEC.
- EXEC (cycle 1), by opcode:
  - 0x1 WRITE: if addr<NUM_REGS, reg[addr]<=data and resp=0xA5A5; else resp=0xEEEE, no write.
  - 0x2 READ: if addr<NUM_REGS, resp=reg[addr]; else resp=0xEEEE.
  - 0x3 SAMPLE: pulse `press_req` this cycle, go to WAIT_SAMP.
  - Any other opcode: resp=0xEEEE (NAK).
  - All non-SAMPLE cases → SEND.
- WAIT_SAMP:
  - Timeout counter starts at 0.
  - `press_vld`=1 → resp=press_data, go to SEND.
  - Counter reaches SAMP_TIMEOUT-1 without `press_vld` → resp=0xDEAD, go to SEND.
  - `press_vld` outside WAIT_SAMP is ignored.
- SEND:
  - `tx_data`<=resp and `trmt`=1 for exactly one cycle (cycle 2 for non-sample commands).
  - Gap counter loads TX_GAP_CYC-1, go to GAP.
- GAP:
  - Decrement counter; at 0 go to IDLE.
  - Next `trmt` is therefore never closer than TX_GAP_CYC+2 cycles to the previous one.
- Read-after-write: a READ immediately following a WRITE to the same address returns the new value.
- Command arrival while busy (feature off): command discarded; `drop_cnt` increments, saturating at 255.
- `cmd_rdy` coinciding with the GAP→IDLE transition cycle counts as busy.
- `busy` is registered and high from cycle 1 through the last GAP cycle.

Optional Feature:
- Macro: CMD_PROC_QUEUE_EN.
- Defined:
  - One-entry holding buffer captures a `cmd` arriving while busy.
  - On GAP→IDLE, a pending buffered command moves straight to EXEC the next cycle, skipping the IDLE wait.
  - `drop_cnt` increments only when the buffer is already full (second command while busy).
- Undefined: no buffer; every command arriving while busy is dropped and counted.

Decomposition:
- Package `cmd_proc_pkg` holds:
  - opcode enum: OP_WRITE=4'h1, OP_READ=4'h2, OP_SAMPLE=4'h3.
  - state enum.
  - response constants: RESP_ACK=16'hA5A5, RESP_NAK=16'hEEEE, RESP_TMO=16'hDEAD.
- One sub-module: `gap_timer`, a loadable down-counter with load/zero flag, instanced for both the TX gap and the sample timeout.

Test Plan:
1. Reset:
   - Stimulus: rst pulsed mid-GAP.
   - Response: trmt/press_req/busy=0, tx_data=0, cfg_regs=0; no `trmt` issued afterwards.
2. Write then read:
   - Stimulus: cmd=24'h13BEEF, then after gap cmd=24'h230000.
   - Response: first trmt with tx_data=0xA5A5 two cycles after cmd_rdy; second trmt with tx_data=0xBEEF; cfg_regs[63:48]=0xBEEF.
3. Sample:
   - Stimulus: cmd=24'h300000; press_vld with press_data=0x1234 five cycles after press_req.
   - Response: press_req pulses at cycle 1; tx_data=0x1234 with trmt the cycle after press_vld.
4. Timeout and NAK:
   - Stimulus: SAMPLE with no press_vld; also cmd=24'h1F0001 with NUM_REGS=8, and opcode 0x7.
   - Response: 0xDEAD after SAMP_TIMEOUT; 0xEEEE for the out-of-range write and for opcode 0x7; registers unchanged.
5. Busy collision:
   - Stimulus: second cmd_rdy during GAP.
   - Feature off: drop_cnt=1, only one trmt.
   - CMD_PROC_QUEUE_EN: second response's trmt issues exactly TX_GAP_CYC+3 cycles after the first; third colliding command increments drop_cnt.
6. Pacing:
   - Stimulus: back-to-back READs, each issued as soon as busy falls.
   - Response: trmt spacing ≥ TX_GAP_CYC+2 cycles in every case.
